nn_weights_loader: RTL and testbench

//  Byte-stream frame parser that programs the network weight memories. Accepts framed bytes (UART/host FIFO side),

---
 rtl/nn_weights_loader_pkg.sv | 42 ++++
 rtl/nn_weights_loader_assembler.sv | 55 +++++
 rtl/nn_weights_loader.sv | 199 +++++++++++++++++++
 tb/tb_nn_weights_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_weights_loader_pkg.sv
// Shared sizes, sync marker, layer ids, FSM states and layer
// dimension helpers for the weights loader.
package nn_weights_loader_pkg;

    localparam int DEF_BITS_PER_WORD = 32;
    localparam int DEF_INPUT_SIZE    = 2;
    localparam int DEF_HIDDEN_SIZE   = 2;
    localparam int DEF_OUTPUT_SIZE   = 1;
    localparam int DEF_BIAS_SIZE     = 1;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    localparam logic LAYER_W1 = 1'b0;
    localparam logic LAYER_W2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAYER,
        ST_DATA,
        ST_CHECK,
        ST_DONE
    } state_t;

    function automatic int layer_rows(
        input logic layer,
        input int   in_sz,
        input int   hid_sz,
        input int   bias_sz
    );
        return (layer == LAYER_W2) ? hid_sz + bias_sz
                                   : in_sz + bias_sz;
    endfunction

    function automatic int layer_cols(
        input logic layer,
        input int   hid_sz,
        input int   out_sz
    );
        return (layer == LAYER_W2) ? out_sz : hid_sz;
    endfunction

endpackage

// File: rtl/nn_weights_loader_assembler.sv
// Little-endian byte-to-word shifter with byte counter and
// running XOR checksum of the frame bytes.
module nn_weights_loader_assembler
    import nn_weights_loader_pkg::*;
#(
    parameter int BITS_PER_WORD = DEF_BITS_PER_WORD
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_clear,
    input  logic                     i_byte_en,
    input  logic                     i_xor_en,
    input  logic [7:0]               i_byte,
    output logic [BITS_PER_WORD-1:0] o_word,
    output logic                     o_word_valid,
    output logic [7:0]               o_xor
);

    localparam int BYTES = BITS_PER_WORD / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [BITS_PER_WORD-9:0] r_shift;
    logic [CW-1:0]            r_count;
    logic [7:0]               r_xor;
    logic [BITS_PER_WORD-1:0] w_word;
    logic                     w_last;

    // Newest byte enters at the top so the first byte ends up as LSB.
    assign w_word       = {i_byte, r_shift};
    assign w_last       = (r_count == CW'(BYTES - 1));
    assign o_word       = w_word;
    assign o_word_valid = i_byte_en && w_last;
    assign o_xor        = r_xor;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shift <= '0;
            r_count <= '0;
            r_xor   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_count <= '0;
            r_xor   <= '0;
        end else begin
            if (i_byte_en) begin
                r_shift <= w_word[BITS_PER_WORD-1:8];
                r_count <= w_last ? '0 : r_count + 1'b1;
            end
            if (i_xor_en) begin
                r_xor <= r_xor ^ i_byte;
            end
        end
    end

endmodule

// File: rtl/nn_weights_loader.sv
// Framed byte-stream parser that writes weight words into the
// network weight memories and reports per-layer load status.
module nn_weights_loader
    import nn_weights_loader_pkg::*;
#(
    parameter int         BITS_PER_WORD       = DEF_BITS_PER_WORD,
    parameter int         INPUT_VECTOR_SIZE   = DEF_INPUT_SIZE,
    parameter int         HIDDEN_LAYER_SIZE   = DEF_HIDDEN_SIZE,
    parameter int         OUTPUT_VECTOR_SIZE  = DEF_OUTPUT_SIZE,
    parameter int         BIAS_SIZE           = DEF_BIAS_SIZE,
    parameter int         CLOG2_MAX_WEIGHTS_N = 2,
    parameter int         CLOG2_MAX_WEIGHTS_M = 2,
    parameter logic [7:0] SYNC_BYTE           = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES      = 1024
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_rx_valid,
    input  logic [7:0]                      i_rx_data,
    output logic                            o_rx_ready,
    output logic                            o_weights_en,
    output logic                            o_weights_layer_address,
    output logic [CLOG2_MAX_WEIGHTS_N-1:0]  o_weights_n_address,
    output logic [CLOG2_MAX_WEIGHTS_M-1:0]  o_weights_m_address,
    output logic signed [BITS_PER_WORD-1:0] o_weights_data,
    output logic                            o_load_done,
    output logic                            o_load_error,
    output logic [1:0]                      o_weights_loaded
);

    localparam int NW = CLOG2_MAX_WEIGHTS_N;
    localparam int MW = CLOG2_MAX_WEIGHTS_M;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                   r_state;
    logic                     r_rx_ready;
    logic                     r_layer;
    logic [NW-1:0]            r_n;
    logic [MW-1:0]            r_m;
    logic [TW-1:0]            r_tmo;
    logic                     r_weights_en;
    logic                     r_wl;
    logic [NW-1:0]            r_wn;
    logic [MW-1:0]            r_wm;
    logic [BITS_PER_WORD-1:0] r_wd;
    logic                     r_load_done;
    logic                     r_load_error;
    logic [1:0]               r_loaded;

    logic                     w_acc;
    logic                     w_clear;
    logic                     w_byte_en;
    logic                     w_xor_en;
    logic                     w_in_frame;
    logic                     w_timeout;
    logic [BITS_PER_WORD-1:0] w_word;
    logic                     w_word_valid;
    logic [7:0]               w_xor;
    logic [NW-1:0]            w_n_last;
    logic [MW-1:0]            w_m_last;
    logic [TW-1:0]            w_tmo_last;

    assign w_acc      = i_rx_valid && r_rx_ready;
    assign w_clear    = (r_state == ST_IDLE) && w_acc &&
                        (i_rx_data == SYNC_BYTE);
    assign w_byte_en  = (r_state == ST_DATA) && w_acc;
    assign w_xor_en   = w_acc && ((r_state == ST_LAYER) ||
                                  (r_state == ST_DATA));
    assign w_in_frame = (r_state == ST_LAYER) ||
                        (r_state == ST_DATA)  ||
                        (r_state == ST_CHECK);
    assign w_tmo_last = TW'(TIMEOUT_CYCLES - 1);
    assign w_timeout  = w_in_frame && !w_acc && (r_tmo == w_tmo_last);

    assign w_n_last = NW'(layer_rows(r_layer, INPUT_VECTOR_SIZE,
                          HIDDEN_LAYER_SIZE, BIAS_SIZE) - 1);
    assign w_m_last = MW'(layer_cols(r_layer, HIDDEN_LAYER_SIZE,
                          OUTPUT_VECTOR_SIZE) - 1);

    nn_weights_loader_assembler #(
        .BITS_PER_WORD (BITS_PER_WORD)
    ) u_asm (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clear      (w_clear),
        .i_byte_en    (w_byte_en),
        .i_xor_en     (w_xor_en),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_xor        (w_xor)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_rx_ready   <= 1'b0;
            r_layer      <= 1'b0;
            r_n          <= '0;
            r_m          <= '0;
            r_tmo        <= '0;
            r_weights_en <= 1'b0;
            r_wl         <= 1'b0;
            r_wn         <= '0;
            r_wm         <= '0;
            r_wd         <= '0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_loaded     <= '0;
        end else begin
            r_rx_ready   <= 1'b1;
            r_weights_en <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;

            if (w_acc) begin
                r_tmo <= '0;
            end else if (w_in_frame) begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_timeout) begin
                r_load_error <= 1'b1;
                r_state      <= ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_clear) begin
                            r_state <= ST_LAYER;
                        end
                    end
                    ST_LAYER: begin
                        if (w_acc) begin
                            if (i_rx_data[7:1] == 7'd0) begin
                                r_layer                <= i_rx_data[0];
                                r_loaded[i_rx_data[0]] <= 1'b0;
                                r_n                    <= '0;
                                r_m                    <= '0;
                                r_state                <= ST_DATA;
                            end else begin
                                r_load_error <= 1'b1;
                                r_state      <= ST_IDLE;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_word_valid) begin
                            r_weights_en <= 1'b1;
                            r_wl         <= r_layer;
                            r_wn         <= r_n;
                            r_wm         <= r_m;
                            r_wd         <= w_word;
                            if (r_m == w_m_last) begin
                                r_m <= '0;
                                if (r_n == w_n_last) begin
                                    r_state <= ST_CHECK;
                                end else begin
                                    r_n <= r_n + 1'b1;
                                end
                            end else begin
                                r_m <= r_m + 1'b1;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (w_acc) begin
                            if (i_rx_data == w_xor) begin
                                r_rx_ready        <= 1'b0;
                                r_load_done       <= 1'b1;
                                r_loaded[r_layer] <= 1'b1;
                                r_state           <= ST_DONE;
                            end else begin
                                r_load_error <= 1'b1;
                                r_state      <= ST_IDLE;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_rx_ready              = r_rx_ready;
    assign o_weights_en            = r_weights_en;
    assign o_weights_layer_address = r_wl;
    assign o_weights_n_address     = r_wn;
    assign o_weights_m_address     = r_wm;
    assign o_weights_data          = r_wd;
    assign o_load_done             = r_load_done;
    assign o_load_error            = r_load_error;
    assign o_weights_loaded        = r_loaded;

endmodule

// File: tb/tb_nn_weights_loader.sv
// Directed bench for nn_weights_loader with a write scoreboard
// and status pulse counters.
module tb_nn_weights_loader;

    localparam int TMO = 1024;

    typedef struct packed {
        logic        layer;
        logic [1:0]  n;
        logic [1:0]  m;
        logic [31:0] data;
    } wr_t;

    logic               clk;
    logic               rst_n;
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               rx_ready;
    logic               w_en;
    logic               w_layer;
    logic [1:0]         w_n;
    logic [1:0]         w_m;
    logic signed [31:0] w_data;
    logic               load_done;
    logic               load_error;
    logic [1:0]         loaded;

    wr_t sb[$];
    int  total;
    int  passed;
    int  done_cnt;
    int  err_cnt;
    int  d0;
    int  e0;
    logic [31:0] wa[6];
    logic [31:0] wb[6];

    nn_weights_loader #(
        .BITS_PER_WORD       (32),
        .INPUT_VECTOR_SIZE   (2),
        .HIDDEN_LAYER_SIZE   (2),
        .OUTPUT_VECTOR_SIZE  (1),
        .BIAS_SIZE           (1),
        .CLOG2_MAX_WEIGHTS_N (2),
        .CLOG2_MAX_WEIGHTS_M (2),
        .SYNC_BYTE           (8'hA5),
        .TIMEOUT_CYCLES      (TMO)
    ) dut (
        .i_clk                   (clk),
        .i_reset_n               (rst_n),
        .i_rx_valid              (rx_valid),
        .i_rx_data               (rx_data),
        .o_rx_ready              (rx_ready),
        .o_weights_en            (w_en),
        .o_weights_layer_address (w_layer),
        .o_weights_n_address     (w_n),
        .o_weights_m_address     (w_m),
        .o_weights_data          (w_data),
        .o_load_done             (load_done),
        .o_load_error            (load_error),
        .o_weights_loaded        (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (w_en) begin
                if (sb.size() == 0) begin
                    check("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    check("wr", {27'd0, w_layer, w_n, w_m, w_data},
                          {27'd0, sb.pop_front()});
                end
            end
            if (load_done)  done_cnt++;
            if (load_error) err_cnt++;
        end
    end

    task automatic send(input logic [7:0] b);
        int w;
        w        = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) check("rx_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic sendg(input logic [7:0] b, input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        if (g > 0) begin
            rx_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
        send(b);
    endtask

    task automatic frame(input logic [7:0] lb, input int nw,
                         input logic [31:0] w[6], input logic bad,
                         input int gap);
        logic [7:0] x;
        logic [7:0] b;
        wr_t        e;
        int         cols;
        cols = lb[0] ? 1 : 2;
        x    = lb;
        sendg(8'hA5, gap);
        sendg(lb, gap);
        for (int k = 0; k < nw; k++) begin
            e.layer = lb[0];
            e.n     = 2'(k / cols);
            e.m     = 2'(k % cols);
            e.data  = w[k];
            sb.push_back(e);
            for (int j = 0; j < 4; j++) begin
                b = w[k][8*j +: 8];
                x = x ^ b;
                sendg(b, gap);
            end
        end
        sendg(bad ? (x ^ 8'h0F) : x, gap);
        rx_valid = 1'b0;
        check("fin_done",  {63'd0, load_done},  {63'd0, !bad});
        check("fin_error", {63'd0, load_error}, {63'd0, bad});
        check("fin_ready", {63'd0, rx_ready},   {63'd0, bad});
        repeat (3) @(negedge clk);
    endtask

    task automatic post(input string tag, input int dd, input int de,
                        input logic [1:0] ld);
        check({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'(dd));
        check({tag, "_err_cnt"},  64'(err_cnt - e0),  64'(de));
        check({tag, "_loaded"},   {62'd0, loaded},    {62'd0, ld});
        check({tag, "_sb_empty"}, 64'(sb.size()),     64'd0);
        d0 = done_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        wr_t e;
        total    = 0;
        passed   = 0;
        done_cnt = 0;
        err_cnt  = 0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_outputs",
              {26'd0, rx_ready, w_en, w_layer, w_n, w_m, load_done,
               load_error, loaded, w_data}, 64'd0);
        repeat (2) @(negedge clk);
        check("rst_ready_held", {63'd0, rx_ready}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {63'd0, rx_ready}, 64'd1);
        d0 = done_cnt;
        e0 = err_cnt;

        for (int k = 0; k < 6; k++) wa[k] = 32'(k + 1) << 16;
        wb    = '{default: 32'd0};
        wb[0] = 32'hFFFF0000;
        wb[1] = 32'h00008000;
        wb[2] = 32'h00020000;

        frame(8'h00, 6, wa, 1'b0, 0);
        post("t1", 1, 0, 2'b01);
        check("t1_hold_data", 64'(w_data), 64'h00060000);
        check("t1_hold_en", {63'd0, w_en}, 64'd0);

        frame(8'h01, 3, wb, 1'b0, 0);
        post("t2", 1, 0, 2'b11);
        frame(8'h01, 3, wb, 1'b0, 3);
        post("t2_gaps", 1, 0, 2'b11);
        check("t2_hold_layer", {63'd0, w_layer}, 64'd1);

        frame(8'h00, 6, wa, 1'b1, 0);
        post("t3", 0, 1, 2'b10);

        send(8'hA5);
        send(8'h02);
        rx_valid = 1'b0;
        check("t4_err_now", {63'd0, load_error}, 64'd1);
        send(8'h11);
        send(8'h22);
        frame(8'h00, 6, wa, 1'b0, 0);
        post("t4", 1, 1, 2'b11);

        send(8'hA5);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        send(8'h01);
        rx_valid = 1'b0;
        c = 0;
        while (!load_error && c < TMO + 20) begin
            @(negedge clk);
            c++;
        end
        check("t5_tmo_cycles",
              {63'd0, (c >= TMO - 1) && (c <= TMO + 1)}, 64'd1);
        repeat (3) @(negedge clk);
        post("t5_tmo", 0, 1, 2'b10);
        frame(8'h00, 6, wa, 1'b0, 0);
        post("t5", 1, 0, 2'b11);

        send(8'hA5);
        send(8'h00);
        e.layer = 1'b0;
        e.n     = 2'd0;
        e.m     = 2'd0;
        e.data  = 32'h00010000;
        sb.push_back(e);
        send(8'h00);
        send(8'h00);
        send(8'h01);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        #2 rst_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("t6_async_rst",
              {26'd0, rx_ready, w_en, w_layer, w_n, w_m, load_done,
               load_error, loaded, w_data}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready", {63'd0, rx_ready}, 64'd1);
        post("t6_rst", 0, 0, 2'b00);
        frame(8'h00, 6, wa, 1'b0, 0);
        post("t6", 1, 0, 2'b01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
